// File: rtl/rate_div_pkg.sv
// rate_div_pkg: shared types and default periods for the rate tick divider.
//   ch_state_t : per-channel lifecycle (IDLE = disabled, RUN = counting, DONE = one-shot fired)
//   mode_t     : periodic or one-shot behaviour of a channel
//   PERIOD_*   : periods, in clock cycles, for common rates at a 50 MHz system clock
package rate_div_pkg;

    localparam int unsigned CLK_HZ       = 50_000_000;
    localparam int unsigned PERIOD_1HZ   = CLK_HZ;
    localparam int unsigned PERIOD_0P5HZ = 2 * CLK_HZ;
    localparam int unsigned PERIOD_10HZ  = CLK_HZ / 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ch_state_t;

    typedef enum logic {
        PERIODIC = 1'b0,
        ONESHOT  = 1'b1
    } mode_t;

endpackage

// File: rtl/rate_div_channel.sv
// rate_div_channel: one programmable divider channel.
// Ports:
//   clock, resetn      : system clock, async active-low reset
//   en                 : count enable (low = pause, count held)
//   clr                : synchronous restart of count and done
//   wr, wr_period,
//   wr_mode            : config load strobe with new period/mode
//   tick               : registered one-cycle pulse at terminal count
//   done               : registered sticky flag, one-shot has fired
module rate_div_channel
    import rate_div_pkg::*;
#(
    parameter int unsigned CNT_W          = 26,
    parameter int unsigned DEFAULT_PERIOD = PERIOD_1HZ
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             en,
    input  logic             clr,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_period,
    input  mode_t            wr_mode,
    output logic             tick,
    output logic             done
);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    mode_t            mode_q, mode_d;
    logic             tick_d;
    logic             done_d;
    logic             at_term_c;

    // Terminal count: the P-th enabled edge sees count == P-1.
    assign at_term_c = (count_q == (period_q - CNT_W'(1)));

    // State, counter and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= RUN;
            count_q  <= '0;
            period_q <= CNT_W'(DEFAULT_PERIOD);
            mode_q   <= PERIODIC;
            tick     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            tick     <= tick_d;
            done     <= done_d;
        end
    end

    // Next state: config write beats clear, clear beats terminal count.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        done_d   = done;

        if (wr) begin
            period_d = wr_period;
            mode_d   = wr_mode;
            count_d  = '0;
            done_d   = 1'b0;
            state_d  = (wr_period == '0) ? IDLE : RUN;
        end else if (clr) begin
            count_d = '0;
            done_d  = 1'b0;
            if (state_q == DONE) begin
                state_d = RUN;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                end
                RUN: begin
                    if (en) begin
                        if (at_term_c) begin
                            count_d = '0;
                            tick_d  = 1'b1;
                            if (mode_q == ONESHOT) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    count_d = '0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rate_tick_divider.sv
// rate_tick_divider: NUM_CH independent runtime-programmable tick dividers.
// Ports:
//   clock, resetn : system clock, async active-low reset
//   ch_en         : per-channel count enable
//   ch_clr        : per-channel synchronous clear of count and done
//   cfg_we        : config write strobe; cfg_ch >= NUM_CH is ignored
//   cfg_ch        : target channel of the write
//   cfg_period    : new period (0 disables the channel)
//   cfg_oneshot   : 1 = one-shot, 0 = periodic
//   tick          : per-channel registered one-cycle pulse
//   done          : per-channel registered sticky one-shot-fired flag
module rate_tick_divider
    import rate_div_pkg::*;
#(
    parameter int unsigned CNT_W          = 26,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DEFAULT_PERIOD = PERIOD_1HZ,
    parameter int unsigned CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] ch_clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] done
);

    mode_t wr_mode_c;

    assign wr_mode_c = cfg_oneshot ? ONESHOT : PERIODIC;

    // Write decode: channel indices at or beyond NUM_CH match no instance.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_c;

        assign wr_c = cfg_we && (cfg_ch == CH_W'(i));

        rate_div_channel #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_channel (
            .clock     (clock),
            .resetn    (resetn),
            .en        (ch_en[i]),
            .clr       (ch_clr[i]),
            .wr        (wr_c),
            .wr_period (cfg_period),
            .wr_mode   (wr_mode_c),
            .tick      (tick[i]),
            .done      (done[i])
        );
    end

endmodule

// File: tb/tb_rate_tick_divider.sv
// tb_rate_tick_divider: directed and randomized check of rate_tick_divider
// against a phase-counting reference model (ticks when the number of enabled
// edges since the last restart is a multiple of the period).
module tb_rate_tick_divider;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned DEF_P  = 7;
    localparam int unsigned CH_W   = 2;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic [NUM_CH-1:0] ch_clr = '0;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_period = '0;
    logic              cfg_oneshot = 1'b0;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] done;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    rate_tick_divider #(
        .CNT_W          (CNT_W),
        .NUM_CH         (NUM_CH),
        .DEFAULT_PERIOD (DEF_P)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .ch_en       (ch_en),
        .ch_clr      (ch_clr),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_oneshot (cfg_oneshot),
        .tick        (tick),
        .done        (done)
    );

    always #5 clock = ~clock;

    // Reference model: per-channel period, mode and enabled-edge count.
    int                m_per [NUM_CH];
    bit                m_os  [NUM_CH];
    int                m_ph  [NUM_CH];
    logic [NUM_CH-1:0] exp_tick;
    logic [NUM_CH-1:0] exp_done;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_per[i]    <= DEF_P;
                m_os[i]     <= 1'b0;
                m_ph[i]     <= 0;
                exp_tick[i] <= 1'b0;
                exp_done[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                int ph;
                ph = m_ph[i] + 1;
                if (cfg_we && (int'(cfg_ch) == i)) begin
                    m_per[i]    <= int'(cfg_period);
                    m_os[i]     <= cfg_oneshot;
                    m_ph[i]     <= 0;
                    exp_tick[i] <= 1'b0;
                    exp_done[i] <= 1'b0;
                end else if (ch_clr[i]) begin
                    m_ph[i]     <= 0;
                    exp_tick[i] <= 1'b0;
                    exp_done[i] <= 1'b0;
                end else if (m_per[i] == 0) begin
                    exp_tick[i] <= 1'b0;
                end else if (m_os[i] && (m_ph[i] >= m_per[i])) begin
                    exp_tick[i] <= 1'b0;
                    exp_done[i] <= 1'b1;
                end else if (ch_en[i]) begin
                    m_ph[i]     <= ph;
                    exp_tick[i] <= ((ph % m_per[i]) == 0);
                    if (m_os[i] && (ph == m_per[i])) begin
                        exp_done[i] <= 1'b1;
                    end
                end else begin
                    exp_tick[i] <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_on) begin
            check("model_tick", 32'(tick), 32'(exp_tick));
            check("model_done", 32'(done), 32'(exp_done));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic write_cfg(input int ch, input int p, input bit os);
        cfg_ch      = CH_W'(ch);
        cfg_period  = CNT_W'(p);
        cfg_oneshot = os;
        cfg_we      = 1'b1;
        step(1);
        cfg_we      = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [6:0] pat;

        #23;
        resetn = 1'b1;
        chk_on = 1'b1;
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        @(posedge clock);
        #1;

        // ch0 P=5 periodic; ch1/ch2 keep the default period of 7.
        ch_en = 3'b111;
        write_cfg(0, 5, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            step(1);
            check("t1_ticks", 32'(tick),
                  32'({((k + 1) % 7) == 0, ((k + 1) % 7) == 0, (k % 5) == 0}));
        end

        // ch1 P=4 with gapped enable: single tick after the 4th enabled edge.
        ch_en = '0;
        write_cfg(1, 4, 1'b0);
        pat = 7'b1100011;
        for (int j = 0; j < 7; j++) begin
            ch_en = {1'b0, pat[j], 1'b0};
            step(1);
            check("t2_tick1", 32'(tick[1]), 32'(j == 6));
        end
        ch_en = '0;
        step(1);
        check("t2_width", 32'(tick[1]), 32'h0);

        // ch2 one-shot P=3, then clear and re-fire.
        write_cfg(2, 3, 1'b1);
        ch_en = 3'b100;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            check("t3_fire", 32'({tick[2], done[2]}), (k == 3) ? 32'h3 : 32'h0);
        end
        cnt = 0;
        repeat (20) begin
            step(1);
            cnt += int'(tick[2]);
        end
        check("t3_no_more_ticks", 32'(cnt), 32'h0);
        check("t3_done_sticky", 32'(done[2]), 32'h1);
        ch_clr = 3'b100;
        step(1);
        ch_clr = '0;
        check("t3_clr_done", 32'(done[2]), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            check("t3_refire", 32'(tick[2]), 32'(k == 3));
        end

        // ch0 rewrite mid-count, rewrite at terminal count, ignored channel index.
        ch_en = 3'b001;
        write_cfg(0, 10, 1'b0);
        step(7);
        write_cfg(0, 3, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            check("t4_rewrite", 32'(tick[0]), 32'(k == 3));
        end
        step(2);
        write_cfg(0, 3, 1'b0);
        check("t4_wr_at_term", 32'(tick[0]), 32'h0);
        write_cfg(3, 1, 1'b1);
        check("t4_bad_ch_done", 32'(done), 32'h4);
        step(1);
        check("t4_bad_ch_a", 32'(tick[0]), 32'h0);
        step(1);
        check("t4_bad_ch_b", 32'(tick[0]), 32'h1);

        // P=0 disables; P=1 ticks every enabled cycle.
        write_cfg(1, 0, 1'b0);
        ch_en = 3'b010;
        cnt = 0;
        repeat (50) begin
            step(1);
            cnt += int'(tick[1]);
        end
        check("t5_p0_ticks", 32'(cnt), 32'h0);
        check("t5_p0_done", 32'(done[1]), 32'h0);
        ch_en = 3'b100;
        write_cfg(2, 1, 1'b0);
        check("t5_p1_wr", 32'(tick[2]), 32'h0);
        repeat (5) begin
            step(1);
            check("t5_p1_tick", 32'(tick[2]), 32'h1);
        end

        // Largest period.
        ch_en = 3'b001;
        write_cfg(0, 255, 1'b0);
        cnt = 0;
        repeat (254) begin
            step(1);
            cnt += int'(tick[0]);
        end
        check("t6_pmax_early", 32'(cnt), 32'h0);
        step(1);
        check("t6_pmax_tick", 32'(tick[0]), 32'h1);

        // Randomized traffic, checked every cycle by the model comparison.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_en[i]  = ($urandom_range(0, 3) != 0);
                ch_clr[i] = ($urandom_range(0, 15) == 0);
            end
            cfg_we      = ($urandom_range(0, 9) == 0);
            cfg_ch      = CH_W'($urandom_range(0, 3));
            cfg_period  = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(0, 255))
                                                      : CNT_W'($urandom_range(0, 6));
            cfg_oneshot = 1'($urandom_range(0, 1));
            step(1);
        end
        cfg_we = 1'b0;
        ch_clr = '0;
        ch_en  = '0;

        // Asynchronous reset with a live tick and a set done flag.
        write_cfg(1, 1, 1'b0);
        write_cfg(2, 2, 1'b1);
        write_cfg(0, 5, 1'b0);
        ch_en = 3'b111;
        step(3);
        check("t7_pre_tick1", 32'(tick[1]), 32'h1);
        check("t7_pre_done2", 32'(done[2]), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check("t7_async_tick", 32'(tick), 32'h0);
        check("t7_async_done", 32'(done), 32'h0);
        #3;
        resetn = 1'b1;
        step(6);
        check("t7_default_early", 32'(tick), 32'h0);
        step(1);
        check("t7_default_tick", 32'(tick), 32'h7);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
